// File: rtl/hbm_axi_responder_pkg.sv
// Shared constants and FSM state encodings for the HBM AXI responder.
// Defaults mirror the CGRA data_path build (beat width, channels, latency).
package hbm_axi_responder_pkg;

    localparam int phit_size    = 512;
    localparam int dwidth_aximm = 64;
    localparam int num_col      = 2;
    localparam int delay_HBM    = 6;

    // Byte-offset bits below the word index.
    localparam int ADDR_LSB = $clog2(phit_size / 8);

    typedef logic [1:0] rd_state_t;
    localparam rd_state_t R_IDLE = 2'd0;
    localparam rd_state_t R_WAIT = 2'd1;
    localparam rd_state_t R_DATA = 2'd2;

    typedef logic [1:0] wr_state_t;
    localparam wr_state_t W_IDLE = 2'd0;
    localparam wr_state_t W_WAIT = 2'd1;
    localparam wr_state_t W_DATA = 2'd2;
    localparam wr_state_t W_RESP = 2'd3;

endpackage

// File: rtl/hbm_axi_channel.sv
// One HBM channel: private word memory, read FSM, write FSM, sticky error.
// Ports: AR/R and AW/W/B AXI4 slave subsets for a single channel, plus err.
module hbm_axi_channel
    import hbm_axi_responder_pkg::*;
#(
    parameter int DATA_W = phit_size,
    parameter int ADDR_W = dwidth_aximm,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = delay_HBM,
    parameter int WR_LAT = 1,
    parameter int LSB    = ADDR_LSB
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic                  arvalid,
    input  logic [7:0]            arlen,
    output logic                  arready,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic                  rlast,
    input  logic                  rready,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic                  awvalid,
    input  logic [7:0]            awlen,
    output logic                  awready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wvalid,
    input  logic                  wlast,
    output logic                  wready,
    output logic                  bvalid,
    input  logic                  bready,
    output logic                  err
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [7:0] RD_LOAD = 8'(RD_LAT - 1);
    localparam logic [7:0] WR_LOAD = 8'(WR_LAT - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    // Only the word-index bits of the addresses matter.
    logic unused_addr;
    assign unused_addr = ^{araddr, awaddr};

    // ---------------- read path ----------------
    rd_state_t        r_state;
    logic             r_live;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_word;
    logic [7:0]       r_len;
    logic [7:0]       r_beat;
    logic [7:0]       r_cnt;
    logic             ar_fire;
    logic             r_fire;

    // r_live keeps the readies low for the reset cycle itself.
    assign arready = r_live && (r_state == R_IDLE);
    assign rvalid  = (r_state == R_DATA);
    assign rlast   = rvalid && (r_beat == r_len);
    assign ar_fire = arvalid && arready;
    assign r_fire  = rvalid && rready;

    // Word to present next: beat 0 when leaving R_WAIT, else beat+1.
    // rdata is registered so it holds under backpressure.
    assign r_word = (r_state == R_WAIT) ? r_idx
                                        : r_idx + IDX_W'(r_beat + 8'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_live  <= 1'b0;
            r_idx   <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_cnt   <= '0;
            rdata   <= '0;
        end else begin
            r_live <= 1'b1;
            unique case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        r_idx   <= araddr[LSB +: IDX_W];
                        r_len   <= arlen;
                        r_beat  <= '0;
                        r_cnt   <= RD_LOAD;
                        r_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_cnt == 8'd0) begin
                        rdata   <= mem[r_word];
                        r_state <= R_DATA;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (rlast) begin
                            rdata   <= '0;
                            r_state <= R_IDLE;
                        end else begin
                            rdata  <= mem[r_word];
                            r_beat <= r_beat + 8'd1;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // ---------------- write path ----------------
    wr_state_t        w_state;
    logic             w_live;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_word;
    logic [7:0]       w_len;
    logic [7:0]       w_beat;
    logic [7:0]       w_cnt;
    logic             aw_fire;
    logic             w_fire;
    logic             w_end;

    assign awready = w_live && (w_state == W_IDLE);
    assign wready  = (w_state == W_DATA);
    assign bvalid  = (w_state == W_RESP);
    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign w_end   = (w_beat == w_len);
    assign w_word  = w_idx + IDX_W'(w_beat);

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_live  <= 1'b0;
            w_idx   <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_cnt   <= '0;
            err     <= 1'b0;
        end else begin
            w_live <= 1'b1;
            unique case (w_state)
                W_IDLE: begin
                    if (aw_fire) begin
                        w_idx   <= awaddr[LSB +: IDX_W];
                        w_len   <= awlen;
                        w_beat  <= '0;
                        w_cnt   <= WR_LOAD;
                        w_state <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (w_cnt == 8'd0) begin
                        w_state <= W_DATA;
                    end else begin
                        w_cnt <= w_cnt - 8'd1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        // Burst length comes from awlen; wlast is only checked.
                        if (wlast != w_end) begin
                            err <= 1'b1;
                        end
                        if (w_end) begin
                            w_state <= W_RESP;
                        end else begin
                            w_beat <= w_beat + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Memory is never reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && w_fire) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[w_word][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/hbm_axi_responder.sv
// Multi-channel behavioural HBM responder: NUM_CH independent AXI4 slaves.
// Ports: per-channel AR/R/AW/W/B buses packed channel-major, plus err_HBM.
module hbm_axi_responder
    import hbm_axi_responder_pkg::*;
#(
    parameter int NUM_CH = num_col,
    parameter int DATA_W = phit_size,
    parameter int ADDR_W = dwidth_aximm,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = delay_HBM,
    parameter int WR_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W*NUM_CH-1:0]     araddr_HBM,
    input  logic [NUM_CH-1:0]            arvalid_HBM,
    input  logic [8*NUM_CH-1:0]          arlen_HBM,
    output logic [NUM_CH-1:0]            arready_HBM,
    output logic [DATA_W*NUM_CH-1:0]     rdata_HBM,
    output logic [NUM_CH-1:0]            rvalid_HBM,
    output logic [NUM_CH-1:0]            rlast_HBM,
    input  logic [NUM_CH-1:0]            rready_HBM,
    input  logic [ADDR_W*NUM_CH-1:0]     awaddr_HBM,
    input  logic [NUM_CH-1:0]            awvalid_HBM,
    input  logic [8*NUM_CH-1:0]          awlen_HBM,
    output logic [NUM_CH-1:0]            awready_HBM,
    input  logic [DATA_W*NUM_CH-1:0]     wdata_HBM,
    input  logic [DATA_W/8*NUM_CH-1:0]   wstrb_HBM,
    input  logic [NUM_CH-1:0]            wvalid_HBM,
    input  logic [NUM_CH-1:0]            wlast_HBM,
    output logic [NUM_CH-1:0]            wready_HBM,
    output logic [NUM_CH-1:0]            bvalid_HBM,
    input  logic [NUM_CH-1:0]            bready_HBM,
    output logic [NUM_CH-1:0]            err_HBM
);

    localparam int SW = DATA_W / 8;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        hbm_axi_channel #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH),
            .RD_LAT (RD_LAT),
            .WR_LAT (WR_LAT),
            .LSB    ($clog2(SW))
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .araddr  (araddr_HBM[i*ADDR_W +: ADDR_W]),
            .arvalid (arvalid_HBM[i]),
            .arlen   (arlen_HBM[i*8 +: 8]),
            .arready (arready_HBM[i]),
            .rdata   (rdata_HBM[i*DATA_W +: DATA_W]),
            .rvalid  (rvalid_HBM[i]),
            .rlast   (rlast_HBM[i]),
            .rready  (rready_HBM[i]),
            .awaddr  (awaddr_HBM[i*ADDR_W +: ADDR_W]),
            .awvalid (awvalid_HBM[i]),
            .awlen   (awlen_HBM[i*8 +: 8]),
            .awready (awready_HBM[i]),
            .wdata   (wdata_HBM[i*DATA_W +: DATA_W]),
            .wstrb   (wstrb_HBM[i*SW +: SW]),
            .wvalid  (wvalid_HBM[i]),
            .wlast   (wlast_HBM[i]),
            .wready  (wready_HBM[i]),
            .bvalid  (bvalid_HBM[i]),
            .bready  (bready_HBM[i]),
            .err     (err_HBM[i])
        );
    end

endmodule

// File: tb/tb_hbm_axi_responder.sv
// Scoreboard testbench for hbm_axi_responder (2 channels, RD_LAT 6, WR_LAT 1).
// A reference memory per channel feeds an expected-beat queue for reads.
module tb_hbm_axi_responder;

    localparam int NCH = 2;
    localparam int DW  = 512;
    localparam int AW  = 64;
    localparam int DEP = 1024;
    localparam int RL  = 6;
    localparam int WL  = 1;
    localparam int SW  = DW / 8;

    logic               clk;
    logic               rst;
    logic [AW*NCH-1:0]  araddr;
    logic [NCH-1:0]     arvalid;
    logic [8*NCH-1:0]   arlen;
    logic [NCH-1:0]     arready;
    logic [DW*NCH-1:0]  rdata;
    logic [NCH-1:0]     rvalid;
    logic [NCH-1:0]     rlast;
    logic [NCH-1:0]     rready;
    logic [AW*NCH-1:0]  awaddr;
    logic [NCH-1:0]     awvalid;
    logic [8*NCH-1:0]   awlen;
    logic [NCH-1:0]     awready;
    logic [DW*NCH-1:0]  wdata;
    logic [SW*NCH-1:0]  wstrb;
    logic [NCH-1:0]     wvalid;
    logic [NCH-1:0]     wlast;
    logic [NCH-1:0]     wready;
    logic [NCH-1:0]     bvalid;
    logic [NCH-1:0]     bready;
    logic [NCH-1:0]     err;

    hbm_axi_responder #(
        .NUM_CH (NCH),
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEP),
        .RD_LAT (RL),
        .WR_LAT (WL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .araddr_HBM  (araddr),
        .arvalid_HBM (arvalid),
        .arlen_HBM   (arlen),
        .arready_HBM (arready),
        .rdata_HBM   (rdata),
        .rvalid_HBM  (rvalid),
        .rlast_HBM   (rlast),
        .rready_HBM  (rready),
        .awaddr_HBM  (awaddr),
        .awvalid_HBM (awvalid),
        .awlen_HBM   (awlen),
        .awready_HBM (awready),
        .wdata_HBM   (wdata),
        .wstrb_HBM   (wstrb),
        .wvalid_HBM  (wvalid),
        .wlast_HBM   (wlast),
        .wready_HBM  (wready),
        .bvalid_HBM  (bvalid),
        .bready_HBM  (bready),
        .err_HBM     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    logic [DW-1:0] ref_mem [NCH][DEP];
    logic [DW-1:0] wbuf [16];
    logic [DW-1:0] exp_q [$];
    logic [NCH-1:0] exp_err;

    task automatic do_read(input int ch, input int word, input int len,
                           input int mode, input int stop_after);
        int n;
        int j;
        int cyc;
        int got;
        logic stalled;
        logic [DW-1:0] hd;
        logic hl;
        logic [DW-1:0] e;
        exp_q.delete();
        for (int k = 0; k <= len; k++) exp_q.push_back(ref_mem[ch][(word + k) % DEP]);
        araddr[ch*AW +: AW] = AW'(word) << 6;
        arlen[ch*8 +: 8] = 8'(len);
        arvalid[ch] = 1'b1;
        n = 0;
        while (!arready[ch] && n < 50) begin @(negedge clk); n++; end
        if (!arready[ch]) begin
            n_chk++; n_fail++;
            $display("FAIL ar_timeout ch%0d: arready=0 required 1", ch);
            arvalid[ch] = 1'b0;
            return;
        end
        @(posedge clk); @(negedge clk);
        arvalid[ch] = 1'b0;
        j = 0;
        while (!rvalid[ch] && j < 100) begin @(negedge clk); j++; end
        n_chk++;
        if (j != RL) begin
            n_fail++;
            $display("FAIL rd_latency ch%0d: got %0d required %0d", ch, j, RL);
        end
        if (!rvalid[ch]) return;
        got = 0; cyc = 0; stalled = 1'b0; hd = '0; hl = 1'b0;
        while (got <= len && cyc < 200) begin
            if (stop_after >= 0 && got == stop_after) break;
            rready[ch] = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
            if (rvalid[ch]) begin
                if (stalled) begin
                    n_chk++;
                    if ({rdata[ch*DW +: DW], rlast[ch]} !== {hd, hl}) begin
                        n_fail++;
                        $display("FAIL rd_stall ch%0d beat %0d: data changed while stalled", ch, got);
                    end
                end
                if (rready[ch]) begin
                    e = exp_q.pop_front();
                    n_chk++;
                    if (rdata[ch*DW +: DW] !== e) begin
                        n_fail++;
                        $display("FAIL rd_data ch%0d beat %0d: got %h required %h",
                                 ch, got, rdata[ch*DW +: DW], e);
                    end
                    n_chk++;
                    if (rlast[ch] !== (got == len)) begin
                        n_fail++;
                        $display("FAIL rd_last ch%0d beat %0d: got %b required %b",
                                 ch, got, rlast[ch], (got == len));
                    end
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hd = rdata[ch*DW +: DW];
                    hl = rlast[ch];
                end
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        rready[ch] = 1'b0;
        if (stop_after >= 0) return;
        n_chk++;
        if (got != len + 1) begin
            n_fail++;
            $display("FAIL rd_beats ch%0d: got %0d required %0d", ch, got, len + 1);
        end
        if (mode == 0) begin
            n_chk++;
            if (cyc != len + 1) begin
                n_fail++;
                $display("FAIL rd_burst_cycles ch%0d: got %0d required %0d", ch, cyc, len + 1);
            end
        end
        n_chk++;
        if (rvalid[ch] !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_idle ch%0d: rvalid=%b required 0", ch, rvalid[ch]);
        end
    endtask

    task automatic do_write(input int ch, input int word, input int len,
                            input logic [SW-1:0] strb, input int last_at,
                            input int stop_after);
        int n;
        int j;
        int w;
        awaddr[ch*AW +: AW] = AW'(word) << 6;
        awlen[ch*8 +: 8] = 8'(len);
        awvalid[ch] = 1'b1;
        n = 0;
        while (!awready[ch] && n < 50) begin @(negedge clk); n++; end
        if (!awready[ch]) begin
            n_chk++; n_fail++;
            $display("FAIL aw_timeout ch%0d: awready=0 required 1", ch);
            awvalid[ch] = 1'b0;
            return;
        end
        @(posedge clk); @(negedge clk);
        awvalid[ch] = 1'b0;
        j = 0;
        while (!wready[ch] && j < 100) begin @(negedge clk); j++; end
        n_chk++;
        if (j != WL) begin
            n_fail++;
            $display("FAIL wr_latency ch%0d: got %0d required %0d", ch, j, WL);
        end
        if (!wready[ch]) return;
        for (int k = 0; k <= len; k++) begin
            if (stop_after >= 0 && k == stop_after) begin
                wvalid[ch] = 1'b0;
                wlast[ch] = 1'b0;
                return;
            end
            wdata[ch*DW +: DW] = wbuf[k];
            wstrb[ch*SW +: SW] = strb;
            wlast[ch] = (k == last_at);
            wvalid[ch] = 1'b1;
            n = 0;
            while (!wready[ch] && n < 50) begin @(negedge clk); n++; end
            if (!wready[ch]) begin
                n_chk++; n_fail++;
                $display("FAIL w_timeout ch%0d beat %0d: wready=0 required 1", ch, k);
                wvalid[ch] = 1'b0;
                return;
            end
            @(posedge clk);
            w = (word + k) % DEP;
            for (int b = 0; b < SW; b++)
                if (strb[b]) ref_mem[ch][w][8*b +: 8] = wbuf[k][8*b +: 8];
            if ((k == last_at) != (k == len)) exp_err[ch] = 1'b1;
            @(negedge clk);
        end
        wvalid[ch] = 1'b0;
        wlast[ch] = 1'b0;
        n_chk++;
        if (bvalid[ch] !== 1'b1) begin
            n_fail++;
            $display("FAIL b_latency ch%0d: bvalid=%b required 1", ch, bvalid[ch]);
        end
        bready[ch] = 1'b1;
        @(posedge clk); @(negedge clk);
        bready[ch] = 1'b0;
        n_chk++;
        if (bvalid[ch] !== 1'b0) begin
            n_fail++;
            $display("FAIL b_clear ch%0d: bvalid=%b required 0", ch, bvalid[ch]);
        end
        n_chk++;
        if (err !== exp_err) begin
            n_fail++;
            $display("FAIL err_flag: got %b required %b", err, exp_err);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_chk++;
        if ({arready, awready, rvalid, rlast, wready, bvalid, err} !== '0) begin
            n_fail++;
            $display("FAIL %s_ctl: ar%b aw%b rv%b rl%b wr%b bv%b er%b required all 0",
                     tag, arready, awready, rvalid, rlast, wready, bvalid, err);
        end
        n_chk++;
        if (rdata !== '0) begin
            n_fail++;
            $display("FAIL %s_rdata: nonzero rdata, required 0", tag);
        end
    endtask

    task automatic check_ready_up(input string tag);
        n_chk++;
        if ({arready, awready} !== {NCH{2'b11}}) begin
            n_fail++;
            $display("FAIL %s_ready: arready=%b awready=%b required all 1",
                     tag, arready, awready);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check_ready_up("reset");
    endtask

    task automatic test_single_read();
        wbuf[0] = '0;
        wbuf[0][319:288] = 32'h40000000;
        do_write(0, 2, 0, '1, 0, -1);
        do_read(0, 2, 0, 0, -1);
    endtask

    task automatic test_burst();
        logic [31:0] flt [8];
        flt = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40a00000,
                32'h40c00000, 32'h40e00000, 32'h41000000, 32'h41100000};
        for (int ch = 0; ch < NCH; ch++) begin
            for (int k = 0; k < 8; k++)
                wbuf[k] = {16{flt[k]}} ^ ((ch == 1) ? {64{8'hA5}} : {DW{1'b0}});
            do_write(ch, 0, 7, '1, 7, -1);
        end
        for (int ch = 0; ch < NCH; ch++) do_read(ch, 0, 7, 0, -1);
    endtask

    task automatic test_backpressure();
        do_read(0, 0, 7, 1, -1);
        do_read(1, 0, 7, 1, -1);
    endtask

    task automatic test_strobe();
        wbuf[0] = '0;
        do_write(1, 100, 0, '1, 0, -1);
        wbuf[0] = '1;
        do_write(1, 100, 0, 64'h1, 0, -1);
        do_read(1, 100, 0, 0, -1);
    endtask

    task automatic test_wrap_err();
        wbuf[0] = {16{32'hDEAD0001}};
        wbuf[1] = {16{32'hBEEF0002}};
        do_write(0, DEP - 1, 1, '1, 1, -1);
        do_read(0, DEP - 1, 1, 0, -1);
        for (int k = 0; k < 4; k++) wbuf[k] = {16{32'h1234_0000 + 32'(k)}};
        do_write(1, 300, 3, '1, 1, -1);
        wbuf[0] = {16{32'hCAFE_F00D}};
        do_write(1, 310, 0, '1, 0, -1);
    endtask

    task automatic test_reset_mid();
        do_read(0, 0, 7, 0, 2);
        for (int k = 0; k < 4; k++) wbuf[k] = {16{32'h7700_0000 + 32'(k)}};
        do_write(1, 200, 3, '1, 3, 2);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check_reset_outputs("midrst");
        exp_err = '0;
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check_ready_up("midrst");
        do_read(1, 200, 1, 0, -1);
        do_read(0, 0, 7, 0, -1);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        exp_err = '0;
        rst = 1'b1;
        araddr = '0; arvalid = '0; arlen = '0; rready = '0;
        awaddr = '0; awvalid = '0; awlen = '0;
        wdata = '0; wstrb = '0; wvalid = '0; wlast = '0; bready = '0;
        for (int c = 0; c < NCH; c++)
            for (int w = 0; w < DEP; w++) ref_mem[c][w] = '0;
        for (int k = 0; k < 16; k++) wbuf[k] = '0;
        test_reset();
        test_single_read();
        test_burst();
        test_backpressure();
        test_strobe();
        test_wrap_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
